// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller/datapath pair.
// The controller drives {s1,s2} with these encodings in state C and D.
package multicycle_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOADB = 2'b00;
  localparam op_t OP_ADD   = 2'b10;
  localparam op_t OP_SUB   = 2'b01;
  localparam op_t OP_RSVD  = 2'b11;

  // True for the two encodings that produce an arithmetic result.
  function automatic logic is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational WIDTH-bit add/subtract unit.
// o_carry is the carry-out for add and the borrow (a < b unsigned) for subtract.
// o_overflow follows the two's-complement sign rule for the selected operation.
module mc_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH:0] w_ext;
  logic           w_sign_a;
  logic           w_sign_b;
  logic           w_sign_r;

  // Zero-extended operands: bit WIDTH of the difference is exactly the borrow.
  assign w_ext = i_sub ? ({1'b0, i_a} - {1'b0, i_b})
                       : ({1'b0, i_a} + {1'b0, i_b});

  assign o_sum   = w_ext[WIDTH-1:0];
  assign o_carry = w_ext[WIDTH];

  assign w_sign_a = i_a[WIDTH-1];
  assign w_sign_b = i_b[WIDTH-1];
  assign w_sign_r = w_ext[WIDTH-1];

  // Add overflows when like-signed operands give a differently signed sum;
  // subtract overflows when unlike-signed operands flip the minuend's sign.
  assign o_overflow = i_sub ? ((w_sign_a != w_sign_b) && (w_sign_r != w_sign_a))
                            : ((w_sign_a == w_sign_b) && (w_sign_r != w_sign_a));

endmodule

// File: rtl/multicycle_datapath.sv
// Datapath driven by the multicycle controller's control word.
// Holds accumulator, operand register, flags and the result/valid/ack handshake;
// arithmetic itself lives in mc_alu.
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             e,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             done,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             carry,
  output logic             overflow,
  output logic             overrun,
  output logic             error
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_carry;
  logic             r_overflow;
  logic             r_overrun;
  logic             r_error;

  op_t              w_op;
  logic             w_capture;
  logic [WIDTH-1:0] w_sum;
  logic             w_alu_carry;
  logic             w_alu_overflow;

  assign w_op = {s1, s2};

  // s0/s1/s2 may be X while e=0, so every use of the decode is qualified by e.
  assign w_capture = e && done && s0 && is_arith(w_op);

  mc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a        (r_acc),
    .i_b        (r_opb),
    .i_sub      (w_op == OP_SUB),
    .o_sum      (w_sum),
    .o_carry    (w_alu_carry),
    .o_overflow (w_alu_overflow)
  );

  // Control-word decode: operand loads, accumulate, flags and reserved-op detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_opb      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else if (e) begin
      // NOTE: non-blocking assignments here let r_acc read its old value in the
      // ALU this cycle while the new value is scheduled for the edge.
      if (!s0) begin
        r_acc <= data_a;
      end else begin
        case (w_op)
          OP_LOADB: r_opb <= data_b;
          OP_ADD,
          OP_SUB: begin
            r_acc      <= w_sum;
            r_carry    <= w_alu_carry;
            r_overflow <= w_alu_overflow;
          end
          default: r_error <= 1'b1;
        endcase
      end
    end
  end

  // Result capture and valid/ack handshake; a capture always beats an ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (w_capture) begin
      r_result       <= w_sum;
      r_result_valid <= 1'b1;
      if (r_result_valid && !result_ack) begin
        r_overrun <= 1'b1;
      end
    end else if (result_ack) begin
      r_result_valid <= 1'b0;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign carry        = r_carry;
  assign overflow     = r_overflow;
  assign overrun      = r_overrun;
  assign error        = r_error;

endmodule
